// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings and constants for the divider issue controller and its helpers.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_special_detect.sv
// Recognises RISC-V divide-by-zero and signed-overflow requests and computes
// their architectural result so they can bypass the divider core.
module div_special_detect
  import div_issue_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic div_by_zero;
  logic signed_ovf;

  assign div_by_zero = (rs2 == 32'd0);
  assign signed_ovf  = !op[0] && (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF);

  // op[1] selects remainder over quotient; divide by zero wins over overflow.
  always_comb begin
    is_special     = div_by_zero || signed_ovf;
    special_result = 32'd0;
    if (div_by_zero) begin
      special_result = op[1] ? rs1 : DIV_BY_ZERO_Q;
    end else if (signed_ovf) begin
      special_result = op[1] ? 32'd0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for the free-running divider core: holds operands for the
// core latency, captures quotient or remainder, and stalls the pipeline while busy.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 36,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] dv_number1,
  output logic [31:0] dv_number2,
  output logic        dv_sign_mode,
  input  logic [31:0] dv_ans,
  input  logic [31:0] dv_remind,
  input  logic        dv_ans_ready
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic              op_rem_q;
  logic              accept;
  logic              capture;
  logic              is_special;
  logic [31:0]       special_result;

  div_special_detect u_special (
    .op             (req_op),
    .rs1            (req_rs1),
    .rs2            (req_rs2),
    .is_special     (is_special),
    .special_result (special_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // kill dominates every state; the core has no timeout, so RUN waits on ready forever.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !kill) begin
          accept     = 1'b1;
          state_next = is_special ? RESP : RUN;
        end
      end
      RUN: begin
        if (kill) begin
          state_next = IDLE;
        end else if ((cnt == '0) && dv_ans_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == RESP) && !kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_number1   <= 32'd0;
      dv_number2   <= 32'd0;
      dv_sign_mode <= 1'b1;
      op_rem_q     <= 1'b0;
      cnt          <= '0;
      result       <= 32'd0;
    end else begin
      if (accept) begin
        dv_number1   <= req_rs1;
        dv_number2   <= req_rs2;
        dv_sign_mode <= req_op[0];
        op_rem_q     <= req_op[1];
        cnt          <= is_special ? '0 : CNT_LOAD;
        if (is_special) begin
          result <= special_result;
        end
      end else if ((state == RUN) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        result <= op_rem_q ? dv_remind : dv_ans;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural divider core whose
// ready flag follows the busy time plus a programmable extra wait.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int DIV_LATENCY = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = 32'd0;
  logic [31:0] req_rs2 = 32'd0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] dv_number1;
  logic [31:0] dv_number2;
  logic        dv_sign_mode;
  logic [31:0] dv_ans;
  logic [31:0] dv_remind;
  logic        dv_ans_ready;

  typedef struct {
    logic [31:0] result;
    int          latency;
    int          issued;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy_cycles = 0;
  int   extra_wait = 0;
  int   total = 0;
  int   passed = 0;

  div_issue_ctrl #(.DIV_LATENCY(DIV_LATENCY), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .kill         (kill),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .dv_number1   (dv_number1),
    .dv_number2   (dv_number2),
    .dv_sign_mode (dv_sign_mode),
    .dv_ans       (dv_ans),
    .dv_remind    (dv_remind),
    .dv_ans_ready (dv_ans_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    busy_cycles <= busy ? busy_cycles + 1 : 0;
  end

  // Behavioural core: results only look valid once ready, so early captures show up.
  logic [31:0] core_q;
  logic [31:0] core_r;
  always_comb begin
    core_q = 32'd0;
    core_r = 32'd0;
    if (dv_number2 != 32'd0) begin
      if (dv_sign_mode) begin
        core_q = dv_number1 / dv_number2;
        core_r = dv_number1 % dv_number2;
      end else if ((dv_number1 == INT_MIN) && (dv_number2 == 32'hFFFF_FFFF)) begin
        core_q = INT_MIN;
        core_r = 32'd0;
      end else begin
        core_q = $signed(dv_number1) / $signed(dv_number2);
        core_r = $signed(dv_number1) % $signed(dv_number2);
      end
    end
  end

  assign dv_ans_ready = busy && (busy_cycles >= DIV_LATENCY - 1 + extra_wait);
  assign dv_ans       = dv_ans_ready ? core_q : 32'hDEAD_BEEF;
  assign dv_remind    = dv_ans_ready ? core_r : 32'hBEEF_DEAD;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: pops an expectation on every done and tracks operand stability while busy.
  logic [31:0] snap1;
  logic [31:0] snap2;
  logic        snap_s;
  logic        prev_busy = 1'b0;
  logic        unstable = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy && !prev_busy) begin
          snap1 = dv_number1;
          snap2 = dv_number2;
          snap_s = dv_sign_mode;
          unstable = 1'b0;
        end else if (busy && ((dv_number1 !== snap1) || (dv_number2 !== snap2) || (dv_sign_mode !== snap_s))) begin
          unstable = 1'b1;
        end
        if (done) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_result"}, result, e.result);
            checkOutput({e.name, "_latency"}, 32'(cyc - e.issued), 32'(e.latency));
            if (e.latency > 1) begin
              checkOutput({e.name, "_dv_stable"}, {31'd0, unstable}, 32'd0);
            end
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checkOutput("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic issueRequest(input string name, input logic [1:0] op, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] exp_res, input int lat);
    exp_t e;
    e.result = exp_res;
    e.latency = lat;
    e.issued = cyc;
    e.name = name;
    sb.push_back(e);
    req_op = op;
    req_rs1 = rs1;
    req_rs2 = rs2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitDrained();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    checkOutput("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] exp_res, input int lat,
                               input int extra);
    waitIdle();
    extra_wait = extra;
    issueRequest(name, op, rs1, rs2, exp_res, lat);
    waitDrained();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_sign_mode"}, {31'd0, dv_sign_mode}, 32'd1);
    checkOutput({tag, "_number1"}, dv_number1, 32'd0);
    checkOutput({tag, "_number2"}, dv_number2, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkReset("por");

    applyStimulus("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LATENCY + 1, 0);
    applyStimulus("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LATENCY + 1, 0);
    applyStimulus("divu_by0",  OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0);
    applyStimulus("remu_by0",  OP_REMU, 32'd100, 32'd0, 32'd100, 1, 0);
    applyStimulus("div_ovf",   OP_DIV,  INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1, 0);
    applyStimulus("rem_ovf",   OP_REM,  INT_MIN, 32'hFFFF_FFFF, 32'd0, 1, 0);
    applyStimulus("divu_big",  OP_DIVU, INT_MIN, 32'hFFFF_FFFF, 32'd0, DIV_LATENCY + 1, 0);
    applyStimulus("divu_slow", OP_DIVU, 32'd1000, 32'd7, 32'd142, DIV_LATENCY + 6, 5);
    applyStimulus("remu_7",    OP_REMU, 32'd1000, 32'd7, 32'd6, DIV_LATENCY + 1, 0);

    // kill in IDLE must block a coincident request
    waitIdle();
    req_op = OP_DIVU; req_rs1 = 32'd9; req_rs2 = 32'd3;
    req_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    checkOutput("idle_kill_busy", {31'd0, busy}, 32'd0);

    // kill mid-RUN, then an immediate new request
    waitIdle();
    extra_wait = 0;
    req_op = OP_DIVU; req_rs1 = 32'd50; req_rs2 = 32'd5;
    req_valid = 1'b1;
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checkOutput("kill_busy", {31'd0, busy}, 32'd0);
    checkOutput("kill_result", result, 32'd6);
    issueRequest("after_kill", OP_DIVU, 32'd81, 32'd9, 32'd9, DIV_LATENCY + 1);
    waitDrained();

    // reset held 3 cycles in the middle of RUN
    waitIdle();
    req_op = OP_REMU; req_rs1 = 32'd77; req_rs2 = 32'd10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkReset("mid_rst");
    repeat (DIV_LATENCY + 4) @(negedge clk);
    checkOutput("mid_rst_no_done_pending", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
